// File: rtl/gate_vector_sequencer_pkg.sv
// rtl/gate_vector_sequencer_pkg.sv - shared state encoding, y_in bit indices and golden gate vectors
package gate_vector_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // y_in bit positions, MSB first: {yand,ynand,yor,ynor,ynot,yxor,yxnor}
   localparam int IDX_AND  = 6;
   localparam int IDX_NAND = 5;
   localparam int IDX_OR   = 4;
   localparam int IDX_NOR  = 3;
   localparam int IDX_NOT  = 2;
   localparam int IDX_XOR  = 1;
   localparam int IDX_XNOR = 0;

   localparam logic [6:0] EXP_00 = 7'b0101101;
   localparam logic [6:0] EXP_01 = 7'b0110110;
   localparam logic [6:0] EXP_10 = 7'b0110010;
   localparam logic [6:0] EXP_11 = 7'b1010001;

endpackage

// File: rtl/gate_golden_model.sv
// rtl/gate_golden_model.sv - combinational {a,b} to expected 7-bit gate output vector
module gate_golden_model
   import gate_vector_sequencer_pkg::*;
(
   input  logic [1:0] i_ab,
   output logic [6:0] o_exp
);

   always_comb begin
      o_exp = EXP_00;
      case (i_ab)
         2'b00:   o_exp = EXP_00;
         2'b01:   o_exp = EXP_01;
         2'b10:   o_exp = EXP_10;
         2'b11:   o_exp = EXP_11;
         default: o_exp = EXP_00;
      endcase
   end

endmodule

// File: rtl/gate_vector_sequencer.sv
// rtl/gate_vector_sequencer.sv - clocked a/b sweep of a two-input gate block with golden compare and scoring
module gate_vector_sequencer
   import gate_vector_sequencer_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned NUM_PASSES  = 1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic [6:0] y_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [3:0] fail_vec,
   output logic [6:0] err_bits
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [5:0] PASS_LAST = 6'(NUM_PASSES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_vec;
   logic [7:0] r_hold;
   logic [5:0] r_pass;
   logic       r_a;
   logic       r_b;
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_err_count;
   logic [3:0] r_fail_vec;
   logic [6:0] r_err_bits;

   logic [6:0] w_exp;
   logic [6:0] w_diff;
   logic [1:0] w_vec_nxt;
   logic       w_start;
   logic       w_cmp;
   logic       w_last;

   gate_golden_model u_golden (
      .i_ab  (r_vec),
      .o_exp (w_exp)
   );

   assign w_diff    = y_in ^ w_exp;
   assign w_vec_nxt = r_vec + 2'd1;
   assign w_start   = start && (r_state != ST_DRIVE);
   // y_in is only looked at on the last cycle of each vector's hold window
   assign w_cmp     = (r_state == ST_DRIVE) && (r_hold == HOLD_LAST);
   assign w_last    = w_cmp && (r_vec == 2'd3) && (r_pass == PASS_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start)  w_state_nxt = ST_DRIVE;
         ST_DRIVE: if (w_last) w_state_nxt = ST_DONE;
         ST_DONE:  if (start)  w_state_nxt = ST_DRIVE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec       <= 2'd0;
         r_hold      <= 8'd0;
         r_pass      <= 6'd0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err_count <= 8'd0;
         r_fail_vec  <= 4'd0;
         r_err_bits  <= 7'd0;
      end else if (w_start) begin
         r_vec       <= 2'd0;
         r_hold      <= 8'd0;
         r_pass      <= 6'd0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_err_count <= 8'd0;
         r_fail_vec  <= 4'd0;
         r_err_bits  <= 7'd0;
      end else if (r_state == ST_DRIVE) begin
         if (w_cmp) begin
            if (w_diff != 7'd0) begin
               if (r_err_count != 8'hFF) begin
                  r_err_count <= r_err_count + 8'd1;
               end
               r_fail_vec[r_vec] <= 1'b1;
               r_err_bits        <= r_err_bits | w_diff;
            end
            if (w_last) begin
               // a/b are left on the final vector once the run ends
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_vec  <= w_vec_nxt;
               r_a    <= w_vec_nxt[1];
               r_b    <= w_vec_nxt[0];
               r_hold <= 8'd0;
               if (r_vec == 2'd3) begin
                  r_pass <= r_pass + 6'd1;
               end
            end
         end else begin
            r_hold <= r_hold + 8'd1;
         end
      end
   end

   assign a         = r_a;
   assign b         = r_b;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_done && (r_err_count == 8'd0);
   assign err_count = r_err_count;
   assign fail_vec  = r_fail_vec;
   assign err_bits  = r_err_bits;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb/tb_gate_vector_sequencer.sv - directed and randomized runs of gate_vector_sequencer against a gate block and score model
module tb_gate_vector_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] start_v;
   logic [3:0] glitch_v;
   logic [6:0] s1_v [4];
   logic [6:0] s0_v [4];

   wire  [3:0] a_v, b_v, busy_v, done_v, pass_v;
   wire  [7:0] errc_v [4];
   wire  [3:0] fv_v   [4];
   wire  [6:0] eb_v   [4];
   wire  [6:0] y_v    [4];

   int total = 0;
   int bad   = 0;

   int hold_p  [4] = '{2, 2, 1, 3};
   int npass_p [4] = '{1, 3, 1, 1};
   logic [6:0] golden [4] = '{7'b0101101, 7'b0110110, 7'b0110010, 7'b1010001};

   always #5 clk = ~clk;

   function automatic logic [6:0] gate_out(input logic ga, input logic gb);
      return {ga & gb, ~(ga & gb), ga | gb, ~(ga | gb), ~ga, ga ^ gb, ~(ga ^ gb)};
   endfunction

   // gate block with stuck-at faults and whole-vector glitch injection
   for (genvar g = 0; g < 4; g++) begin : g_gate
      assign y_v[g] = ((gate_out(a_v[g], b_v[g]) | s1_v[g]) & ~s0_v[g]) ^ {7{glitch_v[g]}};
   end

   gate_vector_sequencer #(.HOLD_CYCLES(2), .NUM_PASSES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .y_in(y_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(errc_v[0]),
      .fail_vec(fv_v[0]), .err_bits(eb_v[0]));
   gate_vector_sequencer #(.HOLD_CYCLES(2), .NUM_PASSES(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .y_in(y_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(errc_v[1]),
      .fail_vec(fv_v[1]), .err_bits(eb_v[1]));
   gate_vector_sequencer #(.HOLD_CYCLES(1), .NUM_PASSES(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .y_in(y_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(errc_v[2]),
      .fail_vec(fv_v[2]), .err_bits(eb_v[2]));
   gate_vector_sequencer #(.HOLD_CYCLES(3), .NUM_PASSES(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]), .y_in(y_v[3]),
      .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(errc_v[3]),
      .fail_vec(fv_v[3]), .err_bits(eb_v[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one complete run on instance idx; expectations come from the truth table and fault masks
   task automatic run(input int idx, input logic [6:0] s1, input logic [6:0] s0,
                      input bit glitch, input bit mid_start);
      int hold, passes, ncyc, nfail, exp_err;
      logic [3:0] exp_fv;
      logic [6:0] exp_eb, y, d;
      hold   = hold_p[idx];
      passes = npass_p[idx];
      ncyc   = 4 * hold * passes;
      nfail  = 0;
      exp_fv = 4'd0;
      exp_eb = 7'd0;
      for (int v = 0; v < 4; v++) begin
         y = (gate_out(v[1], v[0]) | s1) & ~s0;
         d = y ^ golden[v];
         if (d != 7'd0) begin
            nfail++;
            exp_fv[v] = 1'b1;
            exp_eb    = exp_eb | d;
         end
      end
      exp_err = (nfail * passes > 255) ? 255 : nfail * passes;

      s1_v[idx]     = s1;
      s0_v[idx]     = s0;
      glitch_v[idx] = 1'b0;
      @(negedge clk);
      start_v[idx] = 1'b1;
      @(posedge clk);
      #1;
      start_v[idx] = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         chk($sformatf("busy[%0d] k=%0d", idx, k), busy_v[idx], 1);
         chk($sformatf("ab[%0d] k=%0d", idx, k), {a_v[idx], b_v[idx]}, (k / hold) % 4);
         chk($sformatf("done_lo[%0d] k=%0d", idx, k), done_v[idx], 0);
         if (k == 0) begin
            chk($sformatf("errc_clr[%0d]", idx), errc_v[idx], 0);
            chk($sformatf("fv_clr[%0d]", idx), fv_v[idx], 0);
            chk($sformatf("eb_clr[%0d]", idx), eb_v[idx], 0);
         end
         start_v[idx]  = mid_start && (k == 3);
         glitch_v[idx] = glitch && ((k % hold) != hold - 1);
         @(posedge clk);
         #1;
      end
      glitch_v[idx] = 1'b0;
      start_v[idx]  = 1'b0;
      chk($sformatf("busy_end[%0d]", idx), busy_v[idx], 0);
      chk($sformatf("done[%0d]", idx), done_v[idx], 1);
      chk($sformatf("ab_end[%0d]", idx), {a_v[idx], b_v[idx]}, 3);
      chk($sformatf("err_count[%0d]", idx), errc_v[idx], exp_err);
      chk($sformatf("fail_vec[%0d]", idx), fv_v[idx], exp_fv);
      chk($sformatf("err_bits[%0d]", idx), eb_v[idx], exp_eb);
      chk($sformatf("pass[%0d]", idx), pass_v[idx], (exp_err == 0) ? 1 : 0);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("done_sticky[%0d]", idx), done_v[idx], 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      start_v  = 4'd0;
      glitch_v = 4'd0;
      for (int i = 0; i < 4; i++) begin
         s1_v[i] = 7'd0;
         s0_v[i] = 7'd0;
      end
      #2;
      chk("rst_a", a_v[0], 0);
      chk("rst_b", b_v[0], 0);
      chk("rst_busy", busy_v[0], 0);
      chk("rst_done", done_v[0], 0);
      chk("rst_pass", pass_v[0], 0);
      chk("rst_errc", errc_v[0], 0);
      chk("rst_fv", fv_v[0], 0);
      chk("rst_eb", eb_v[0], 0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_busy", busy_v[0], 0);

      run(0, 7'd0, 7'd0, 1'b0, 1'b0);
      run(0, 7'b1000000, 7'd0, 1'b0, 1'b0);
      run(1, 7'd0, 7'b0000001, 1'b0, 1'b0);
      run(0, 7'b1000000, 7'd0, 1'b0, 1'b1);
      run(0, 7'd0, 7'd0, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         logic [6:0] rs1, rs0;
         rs1 = 7'($urandom) & 7'($urandom);
         rs0 = 7'($urandom) & 7'($urandom) & ~rs1;
         run(r % 2, rs1, rs0, 1'b0, (r % 2) == 0);
      end

      run(2, 7'd0, 7'd0, 1'b0, 1'b0);
      run(3, 7'd0, 7'd0, 1'b1, 1'b0);

      // asynchronous reset in the middle of a failing run
      s1_v[0] = 7'b1000000;
      s0_v[0] = 7'd0;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst_a", a_v[0], 1);
      chk("pre_rst_errc", errc_v[0], 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_a", a_v[0], 0);
      chk("async_b", b_v[0], 0);
      chk("async_busy", busy_v[0], 0);
      chk("async_errc", errc_v[0], 0);
      chk("async_fv", fv_v[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_busy", busy_v[0], 0);
      chk("post_rst_done", done_v[0], 0);
      chk("post_rst_ab", {a_v[0], b_v[0]}, 0);
      chk("post_rst_errc", errc_v[0], 0);
      run(0, 7'd0, 7'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
